i2c_sensor_target: RTL and testbench

Synthesizable I2C target (responder) that emulates the temperature/humidity sensor on the far end of the ck_scl/ck_sda bus that i2c_master drives. It decodes the master's address, command-write and measurement-read transactions, ACKs its own address, and returns a 16-bit measurement word MSB-first. Used in the loopback bench and as an on-board stand-in for the sensor, with SDA wired open-drain through the top-level tristate.

---
 rtl/i2c_pkg.sv | 30 +++
 rtl/i2c_sensor_target_if.sv | 10 +
 rtl/i2c_line_filter.sv | 51 +++++
 rtl/i2c_sensor_target.sv | 214 +++++++++++++++++++++
 tb/tb_i2c_sensor_target.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM encoding, ACK levels, sensor address and command codes.
// Used by the sensor target and by the master that talks to it.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrByte,
        StWrAck,
        StRdByte,
        StRdAck,
        StIgnore
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [6:0] SENSOR_ADDR = 7'h40;

    localparam logic [7:0] CMD_MEAS_TEMP = 8'hE3;
    localparam logic [7:0] CMD_MEAS_RH   = 8'hE5;
    localparam logic [7:0] CMD_SOFT_RST  = 8'hFE;

    // Address byte as it appears on the wire: 7-bit address followed by R/W.
    function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rw);
        return {addr, rw};
    endfunction

endpackage

// File: rtl/i2c_sensor_target_if.sv
// Pad-side I2C signals between the bus and the sensor target.
// SDA is open-drain: the target only ever requests a pull-low through sda_oe.
interface i2c_sensor_target_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus a FILTER_LEN-cycle glitch filter for one I2C line.
// Produces the filtered level and single-cycle rise/fall pulses aligned with it.
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk100MHz,
    input  logic rst_n,
    input  logic line_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]      sync_q;
    logic            filt_q;
    logic            rise_q;
    logic            fall_q;
    logic [CntW-1:0] cnt_q;

    // Preset to 1 so a reset looks like an idle bus.
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_raw};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntW'(FILTER_LEN - 1)) begin
                filt_q <= sync_q[1];
                cnt_q  <= '0;
                rise_q <= sync_q[1];
                fall_q <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = filt_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/i2c_sensor_target.sv
// I2C target emulating the temperature/humidity sensor: ACKs its address, captures the
// command byte of writes and returns a 16-bit measurement MSB-first on reads.
module i2c_sensor_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDR   = SENSOR_ADDR,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic                 clk100MHz,
    input  logic                 rst_n,
    i2c_sensor_target_if.slave   bus,
    input  logic [15:0]          meas_data,
    output logic [7:0]           cmd_byte,
    output logic                 cmd_strobe,
    output logic                 busy
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk100MHz (clk100MHz),
        .rst_n     (rst_n),
        .line_raw  (bus.scl_in),
        .level     (scl_f),
        .rise      (scl_rise),
        .fall      (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk100MHz (clk100MHz),
        .rst_n     (rst_n),
        .line_raw  (bus.sda_in),
        .level     (sda_f),
        .rise      (sda_rise),
        .fall      (sda_fall)
    );

    i2c_state_e  state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        rw_q, rw_d;
    logic [15:0] shadow_q, shadow_d;
    logic        byte_idx_q, byte_idx_d;
    logic        first_q, first_d;
    logic [7:0]  cmd_byte_q, cmd_byte_d;
    logic        cmd_strobe_q, cmd_strobe_d;
    logic        busy_q, busy_d;
    logic        sda_oe_q, sda_oe_d;

    logic       start_det, stop_det;
    logic [7:0] shift_in;
    logic [7:0] rd_byte;
    logic [2:0] bit_sel;

    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;
    assign shift_in  = {shift_q[6:0], sda_f};
    assign rd_byte   = byte_idx_q ? shadow_q[7:0] : shadow_q[15:8];
    assign bit_sel   = 3'd7 - bit_cnt_q[2:0];

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rw_q         <= 1'b0;
            shadow_q     <= '0;
            byte_idx_q   <= 1'b0;
            first_q      <= 1'b0;
            cmd_byte_q   <= '0;
            cmd_strobe_q <= 1'b0;
            busy_q       <= 1'b0;
            sda_oe_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rw_q         <= rw_d;
            shadow_q     <= shadow_d;
            byte_idx_q   <= byte_idx_d;
            first_q      <= first_d;
            cmd_byte_q   <= cmd_byte_d;
            cmd_strobe_q <= cmd_strobe_d;
            busy_q       <= busy_d;
            sda_oe_q     <= sda_oe_d;
        end
    end

    // ACK states use sda_oe_q as phase: first SCL fall drives ACK, second fall leaves the slot.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rw_d         = rw_q;
        shadow_d     = shadow_q;
        byte_idx_d   = byte_idx_q;
        first_d      = first_q;
        cmd_byte_d   = cmd_byte_q;
        cmd_strobe_d = 1'b0;
        busy_d       = busy_q;
        sda_oe_d     = sda_oe_q;

        if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            unique case (state_q)
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (shift_in[7:1] == I2C_ADDR) begin
                                state_d    = StAddrAck;
                                busy_d     = 1'b1;
                                rw_d       = shift_in[0];
                                first_d    = 1'b1;
                                byte_idx_d = 1'b0;
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                            if (rw_q) begin
                                shadow_d   = meas_data;
                                byte_idx_d = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = '0;
                            if (rw_q) begin
                                state_d  = StRdByte;
                                sda_oe_d = ~shadow_q[15];
                            end else begin
                                state_d  = StWrByte;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end
                StWrByte: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            state_d = StWrAck;
                            if (first_q) begin
                                cmd_byte_d   = shift_in;
                                cmd_strobe_d = 1'b1;
                                first_d      = 1'b0;
                            end
                        end
                    end
                end
                StWrAck: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            state_d   = StWrByte;
                            bit_cnt_d = '0;
                        end
                    end
                end
                StRdByte: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = StRdAck;
                        end else begin
                            sda_oe_d = ~rd_byte[bit_sel];
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        if (sda_f == I2C_ACK) begin
                            byte_idx_d = ~byte_idx_q;
                            bit_cnt_d  = '0;
                            state_d    = StRdByte;
                        end else begin
                            state_d = StIgnore;
                        end
                    end
                end
                StIdle, StIgnore: begin
                end
                default: begin
                    state_d  = StIdle;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe = sda_oe_q;
    assign cmd_byte   = cmd_byte_q;
    assign cmd_strobe = cmd_strobe_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_sensor_target.sv
// Bit-banged I2C master driving the sensor target, with scoreboard queues for commands
// and read bytes.
module tb_i2c_sensor_target;
    import i2c_pkg::*;

    localparam int Q = 250;

    logic        clk100MHz = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl_drv = 1'b1;
    logic        sda_drv = 1'b1;
    logic [15:0] meas_data = 16'h6A5C;
    logic [7:0]  cmd_byte;
    logic        cmd_strobe;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int n_strobe = 0;
    logic oe_seen = 1'b0;
    logic [7:0] exp_cmd_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] exp_c;

    i2c_sensor_target_if bus ();

    assign bus.scl_in = scl_drv;
    assign bus.sda_in = sda_drv & ~bus.sda_oe;

    i2c_sensor_target #(
        .I2C_ADDR   (7'h40),
        .FILTER_LEN (4)
    ) dut (
        .clk100MHz  (clk100MHz),
        .rst_n      (rst_n),
        .bus        (bus),
        .meas_data  (meas_data),
        .cmd_byte   (cmd_byte),
        .cmd_strobe (cmd_strobe),
        .busy       (busy)
    );

    always #5 clk100MHz = ~clk100MHz;

    // Command scoreboard: every strobe pops one expected command.
    always @(negedge clk100MHz) begin
        if (bus.sda_oe) oe_seen = 1'b1;
        if (cmd_strobe) begin
            n_strobe++;
            checks++;
            if (exp_cmd_q.size() == 0) begin
                failures++;
                $display("FAIL cmd_unexpected: got cmd_byte=%02h, expected no strobe", cmd_byte);
            end else begin
                exp_c = exp_cmd_q.pop_front();
                if (cmd_byte !== exp_c) begin
                    failures++;
                    $display("FAIL cmd_value: got %02h, expected %02h", cmd_byte, exp_c);
                end
            end
        end
    end

    task automatic i2c_start();
        sda_drv = 1'b0; #Q;
        scl_drv = 1'b0; #Q;
    endtask

    task automatic i2c_rstart();
        sda_drv = 1'b1; #Q;
        scl_drv = 1'b1; #Q;
        sda_drv = 1'b0; #Q;
        scl_drv = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; #Q;
        scl_drv = 1'b1; #Q;
        sda_drv = 1'b1; #Q;
    endtask

    task automatic put_bit(input logic b);
        sda_drv = b; #Q;
        scl_drv = 1'b1; #(2 * Q);
        scl_drv = 1'b0; #Q;
    endtask

    task automatic get_bit(output logic b);
        sda_drv = 1'b1; #Q;
        scl_drv = 1'b1; #Q;
        b = bus.sda_in; #Q;
        scl_drv = 1'b0; #Q;
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(ack);
    endtask

    task automatic check_ack(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got ack=%0b, expected %0b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #100;
        checks++;
        if (bus.sda_oe !== 1'b0) begin
            failures++; $display("FAIL rst_sda_oe: got %0b, expected 0", bus.sda_oe);
        end
        checks++;
        if (cmd_byte !== 8'h00) begin
            failures++; $display("FAIL rst_cmd_byte: got %02h, expected 00", cmd_byte);
        end
        checks++;
        if (cmd_strobe !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_strobe_busy: got strobe=%0b busy=%0b, expected 0 0", cmd_strobe, busy);
        end
        checks++;
        if (dut.state_q !== StIdle) begin
            failures++; $display("FAIL rst_state: got %0d, expected %0d", dut.state_q, StIdle);
        end
        rst_n = 1'b1;
        #100;
    endtask

    task automatic test_write();
        logic ack;
        int s0;
        s0 = n_strobe;
        exp_cmd_q.push_back(CMD_MEAS_TEMP);
        i2c_start();
        put_byte(8'h80, ack);
        check_ack("wr_addr_ack", ack, I2C_ACK);
        put_byte(CMD_MEAS_TEMP, ack);
        check_ack("wr_data_ack", ack, I2C_ACK);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL wr_busy_mid: got %0b, expected 1", busy);
        end
        i2c_stop();
        #100;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL wr_busy_stop: got %0b, expected 0", busy);
        end
        checks++;
        if (n_strobe - s0 != 1 || exp_cmd_q.size() != 0) begin
            failures++;
            $display("FAIL wr_strobe_count: got %0d strobes, expected 1", n_strobe - s0);
        end
    endtask

    task automatic test_read();
        logic ack;
        logic [7:0] d, e;
        meas_data = 16'h6A5C;
        exp_rd_q.push_back(8'h6A);
        exp_rd_q.push_back(8'h5C);
        i2c_start();
        put_byte(8'h81, ack);
        check_ack("rd_addr_ack", ack, I2C_ACK);
        meas_data = 16'hFFFF;
        for (int k = 0; k < 2; k++) begin
            get_byte((k == 1) ? I2C_NACK : I2C_ACK, d);
            e = exp_rd_q.pop_front();
            checks++;
            if (d !== e) begin
                failures++; $display("FAIL rd_byte%0d: got %02h, expected %02h", k, d, e);
            end
        end
        #100;
        checks++;
        if (bus.sda_oe !== 1'b0) begin
            failures++; $display("FAIL rd_released: got sda_oe=%0b, expected 0", bus.sda_oe);
        end
        checks++;
        if (dut.state_q !== StIgnore) begin
            failures++; $display("FAIL rd_ignore: got state %0d, expected %0d", dut.state_q, StIgnore);
        end
        i2c_stop();
        #100;
        checks++;
        if (dut.state_q !== StIdle || busy !== 1'b0) begin
            failures++;
            $display("FAIL rd_stop_idle: got state %0d busy=%0b, expected %0d 0", dut.state_q, busy, StIdle);
        end
        meas_data = 16'h6A5C;
    endtask

    task automatic test_nomatch();
        logic ack;
        int s0;
        s0 = n_strobe;
        i2c_start();
        oe_seen = 1'b0;
        put_byte(8'h82, ack);
        check_ack("nm_addr_nack", ack, I2C_NACK);
        put_byte(CMD_MEAS_TEMP, ack);
        check_ack("nm_data_nack", ack, I2C_NACK);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL nm_busy: got %0b, expected 0", busy);
        end
        i2c_stop();
        #100;
        checks++;
        if (oe_seen !== 1'b0 || n_strobe != s0) begin
            failures++;
            $display("FAIL nm_quiet: got oe_seen=%0b strobes=%0d, expected 0 0", oe_seen, n_strobe - s0);
        end
    endtask

    task automatic test_back_to_back();
        logic ack;
        logic [7:0] d, e;
        int s0;
        s0 = n_strobe;
        meas_data = 16'h6A5C;
        exp_cmd_q.push_back(CMD_MEAS_TEMP);
        exp_rd_q.push_back(8'h6A);
        exp_rd_q.push_back(8'h5C);
        exp_rd_q.push_back(8'h6A);
        exp_rd_q.push_back(8'h5C);
        i2c_start();
        put_byte(8'h80, ack);
        check_ack("b2b_waddr_ack", ack, I2C_ACK);
        put_byte(CMD_MEAS_TEMP, ack);
        check_ack("b2b_cmd_ack", ack, I2C_ACK);
        i2c_rstart();
        put_byte(8'h81, ack);
        check_ack("b2b_raddr_ack", ack, I2C_ACK);
        for (int k = 0; k < 4; k++) begin
            get_byte((k == 3) ? I2C_NACK : I2C_ACK, d);
            e = exp_rd_q.pop_front();
            checks++;
            if (d !== e) begin
                failures++; $display("FAIL b2b_byte%0d: got %02h, expected %02h", k, d, e);
            end
        end
        i2c_stop();
        #100;
        checks++;
        if (n_strobe - s0 != 1) begin
            failures++; $display("FAIL b2b_strobes: got %0d, expected 1", n_strobe - s0);
        end
    endtask

    task automatic test_glitch();
        logic ack;
        logic [7:0] d;
        d = 8'h80;
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            if (i == 4) begin
                sda_drv = d[i]; #Q;
                scl_drv = 1'b1; #Q;
                scl_drv = 1'b0; #30;
                scl_drv = 1'b1; #(Q - 30);
                scl_drv = 1'b0; #Q;
            end else begin
                put_bit(d[i]);
            end
        end
        get_bit(ack);
        check_ack("gl_addr_ack", ack, I2C_ACK);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL gl_busy: got %0b, expected 1", busy);
        end
        i2c_stop();
        #100;
    endtask

    task automatic test_reset_mid();
        logic ack, b;
        int s0;
        meas_data = 16'h6A5C;
        i2c_start();
        put_byte(8'h81, ack);
        check_ack("rm_addr_ack", ack, I2C_ACK);
        checks++;
        if (bus.sda_oe !== 1'b1) begin
            failures++; $display("FAIL rm_drive_bit: got sda_oe=%0b, expected 1", bus.sda_oe);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.sda_oe !== 1'b0) begin
            failures++; $display("FAIL rm_async_release: got sda_oe=%0b, expected 0", bus.sda_oe);
        end
        #99;
        rst_n = 1'b1;
        oe_seen = 1'b0;
        for (int k = 0; k < 4; k++) get_bit(b);
        i2c_stop();
        #100;
        checks++;
        if (oe_seen !== 1'b0) begin
            failures++; $display("FAIL rm_no_drive: got oe_seen=%0b, expected 0", oe_seen);
        end
        s0 = n_strobe;
        exp_cmd_q.push_back(CMD_SOFT_RST);
        i2c_start();
        put_byte(8'h80, ack);
        check_ack("rm_wr_addr_ack", ack, I2C_ACK);
        put_byte(CMD_SOFT_RST, ack);
        check_ack("rm_wr_data_ack", ack, I2C_ACK);
        i2c_stop();
        #100;
        checks++;
        if (n_strobe - s0 != 1 || cmd_byte !== CMD_SOFT_RST) begin
            failures++;
            $display("FAIL rm_fresh_write: got strobes=%0d cmd=%02h, expected 1 %02h",
                     n_strobe - s0, cmd_byte, CMD_SOFT_RST);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nomatch();
        test_back_to_back();
        test_glitch();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        failures++;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
